// File: rtl/rs_station_if.sv
// rs_station_if: decode issue, write-back broadcast and execute dispatch bus of a reservation station
// master: decode / write-back / execution-unit side; slave: the reservation station
interface rs_station_if #(
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32,
  parameter int OP_W   = 6,
  parameter int UNIT_W = 3
);
  logic              issue_valid;
  logic [UNIT_W-1:0] issue_ex_unit;
  logic [OP_W-1:0]   issue_op;
  logic [TAG_W-1:0]  issue_tag1, issue_tag2, issue_target;
  logic [DATA_W-1:0] issue_val1, issue_val2;
  logic              full;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              ex_valid, ex_ready;
  logic [OP_W-1:0]   ex_op;
  logic [DATA_W-1:0] ex_a, ex_b;
  logic [TAG_W-1:0]  ex_target;
  modport master (
    output issue_valid, issue_ex_unit, issue_op, issue_tag1, issue_tag2, issue_val1, issue_val2,
           issue_target, cdb_valid, cdb_tag, cdb_data, ex_ready,
    input  full, ex_valid, ex_op, ex_a, ex_b, ex_target
  );
  modport slave (
    input  issue_valid, issue_ex_unit, issue_op, issue_tag1, issue_tag2, issue_val1, issue_val2,
           issue_target, cdb_valid, cdb_tag, cdb_data, ex_ready,
    output full, ex_valid, ex_op, ex_a, ex_b, ex_target
  );
endinterface

// File: rtl/rs_station.sv
// rs_station: reservation station capturing operands from write-back and dispatching oldest ready entry
// ports: clk, rst (async, active-high), flush (sync discard), bus (issue in, cdb in, ex out, full out)
module rs_station #(
  parameter int ENTRY_NUM = 4,
  parameter int TAG_W     = 5,
  parameter int DATA_W    = 32,
  parameter int OP_W      = 6,
  parameter int UNIT_W    = 3,
  parameter int UNIT_ID   = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  rs_station_if.slave bus
);
  localparam int AW = $clog2(ENTRY_NUM);
  logic [ENTRY_NUM-1:0] valid, ready;
  logic [OP_W-1:0]      op  [ENTRY_NUM];
  logic [TAG_W-1:0]     t1  [ENTRY_NUM];
  logic [TAG_W-1:0]     t2  [ENTRY_NUM];
  logic [TAG_W-1:0]     tgt [ENTRY_NUM];
  logic [DATA_W-1:0]    v1  [ENTRY_NUM];
  logic [DATA_W-1:0]    v2  [ENTRY_NUM];
  logic [AW-1:0]        age [ENTRY_NUM];
  logic [AW-1:0]        free_idx, sel_idx, sel_age;
  logic                 found, acc, load;
  logic                 ex_valid;
  logic [OP_W-1:0]      ex_op;
  logic [DATA_W-1:0]    ex_a, ex_b;
  logic [TAG_W-1:0]     ex_target;
  function automatic logic hit(input logic [TAG_W-1:0] t);
    return bus.cdb_valid && bus.cdb_tag != '0 && t == bus.cdb_tag;
  endfunction
  assign bus.full      = &valid;
  assign bus.ex_valid  = ex_valid;
  assign bus.ex_op     = ex_op;
  assign bus.ex_a      = ex_a;
  assign bus.ex_b      = ex_b;
  assign bus.ex_target = ex_target;
  assign acc  = bus.issue_valid && bus.issue_ex_unit == UNIT_W'(UNIT_ID) && !bus.full;
  assign load = !ex_valid || bus.ex_ready;
  always_comb begin
    free_idx = '0;
    ready    = '0;
    found    = 1'b0;
    sel_idx  = '0;
    sel_age  = '0;
    for (int i = ENTRY_NUM - 1; i >= 0; i--)
      if (!valid[i]) free_idx = AW'(i);
    for (int i = 0; i < ENTRY_NUM; i++) begin
      ready[i] = valid[i] && t1[i] == '0 && t2[i] == '0;
      // strict compare keeps the lowest index on equal ages
      if (ready[i] && (!found || age[i] > sel_age)) begin
        found   = 1'b1;
        sel_idx = AW'(i);
        sel_age = age[i];
      end
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid     <= '0;
      ex_valid  <= 1'b0;
      ex_op     <= '0;
      ex_a      <= '0;
      ex_b      <= '0;
      ex_target <= '0;
      for (int i = 0; i < ENTRY_NUM; i++) begin
        op[i]  <= '0;
        t1[i]  <= '0;
        t2[i]  <= '0;
        tgt[i] <= '0;
        v1[i]  <= '0;
        v2[i]  <= '0;
        age[i] <= '0;
      end
    end else if (flush) begin
      valid    <= '0;
      ex_valid <= 1'b0;
    end else begin
      for (int i = 0; i < ENTRY_NUM; i++)
        if (valid[i]) begin
          if (hit(t1[i])) begin
            t1[i] <= '0;
            v1[i] <= bus.cdb_data;
          end
          if (hit(t2[i])) begin
            t2[i] <= '0;
            v2[i] <= bus.cdb_data;
          end
          if (acc && age[i] != AW'(ENTRY_NUM - 1)) age[i] <= age[i] + 1'b1;
        end
      // free_idx is never valid, so it cannot collide with sel_idx below
      if (acc) begin
        valid[free_idx] <= 1'b1;
        op[free_idx]    <= bus.issue_op;
        tgt[free_idx]   <= bus.issue_target;
        age[free_idx]   <= '0;
        t1[free_idx]    <= hit(bus.issue_tag1) ? '0 : bus.issue_tag1;
        v1[free_idx]    <= hit(bus.issue_tag1) ? bus.cdb_data : bus.issue_val1;
        t2[free_idx]    <= hit(bus.issue_tag2) ? '0 : bus.issue_tag2;
        v2[free_idx]    <= hit(bus.issue_tag2) ? bus.cdb_data : bus.issue_val2;
      end
      if (load) begin
        ex_valid <= found;
        if (found) begin
          valid[sel_idx] <= 1'b0;
          ex_op          <= op[sel_idx];
          ex_a           <= v1[sel_idx];
          ex_b           <= v2[sel_idx];
          ex_target      <= tgt[sel_idx];
        end
      end
    end
endmodule

// File: tb/tb_rs_station.sv
// tb_rs_station: directed self-checking bench for rs_station
module tb_rs_station;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0;
  int tests = 0, fails = 0;
  rs_station_if #(.TAG_W(5), .DATA_W(32), .OP_W(6), .UNIT_W(3)) bus ();
  rs_station #(.ENTRY_NUM(4), .TAG_W(5), .DATA_W(32), .OP_W(6), .UNIT_W(3), .UNIT_ID(0)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [2:0] unit, input logic [5:0] op, input logic [4:0] t1,
                       input logic [31:0] v1, input logic [4:0] t2, input logic [31:0] v2,
                       input logic [4:0] tgt);
    bus.issue_valid = 1'b1;
    bus.issue_ex_unit = unit;
    bus.issue_op = op;
    bus.issue_tag1 = t1;
    bus.issue_val1 = v1;
    bus.issue_tag2 = t2;
    bus.issue_val2 = v2;
    bus.issue_target = tgt;
    tick();
    bus.issue_valid = 1'b0;
  endtask
  task automatic cdb(input logic [4:0] tag, input logic [31:0] data);
    bus.cdb_valid = 1'b1;
    bus.cdb_tag = tag;
    bus.cdb_data = data;
    tick();
    bus.cdb_valid = 1'b0;
  endtask
  initial begin
    bus.issue_valid = 0; bus.issue_ex_unit = 0; bus.issue_op = 0; bus.issue_tag1 = 0;
    bus.issue_tag2 = 0; bus.issue_val1 = 0; bus.issue_val2 = 0; bus.issue_target = 0;
    bus.cdb_valid = 0; bus.cdb_tag = 0; bus.cdb_data = 0; bus.ex_ready = 0;
    tick();
    tick();
    chk("rst_ex_valid", 32'(bus.ex_valid), 0);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_ex_a", bus.ex_a, 0);
    chk("rst_ex_target", 32'(bus.ex_target), 0);
    rst = 0;
    // 1: ready issue, one cycle to dispatch
    issue(0, 5, 0, 10, 0, 20, 3);
    chk("t1_no_bypass", 32'(bus.ex_valid), 0);
    tick();
    chk("t1_valid", 32'(bus.ex_valid), 1);
    chk("t1_op", 32'(bus.ex_op), 5);
    chk("t1_a", bus.ex_a, 10);
    chk("t1_b", bus.ex_b, 20);
    chk("t1_target", 32'(bus.ex_target), 3);
    bus.ex_ready = 1;
    tick();
    chk("t1_drain", 32'(bus.ex_valid), 0);
    // 2: wakeup later, then capture at issue time
    issue(0, 2, 7, 0, 0, 4, 4);
    tick();
    chk("t2_wait", 32'(bus.ex_valid), 0);
    cdb(7, 99);
    chk("t2_wake_no_bypass", 32'(bus.ex_valid), 0);
    tick();
    chk("t2_valid", 32'(bus.ex_valid), 1);
    chk("t2_a", bus.ex_a, 99);
    chk("t2_b", bus.ex_b, 4);
    bus.cdb_valid = 1; bus.cdb_tag = 7; bus.cdb_data = 55;
    issue(0, 2, 7, 0, 0, 8, 8);
    bus.cdb_valid = 0;
    chk("t2_cap_empty", 32'(bus.ex_valid), 0);
    tick();
    chk("t2_cap_valid", 32'(bus.ex_valid), 1);
    chk("t2_cap_a", bus.ex_a, 55);
    chk("t2_cap_b", bus.ex_b, 8);
    tick();
    chk("t2_drain", 32'(bus.ex_valid), 0);
    // 3: fill, reject fifth, drain oldest first
    for (int i = 0; i < 4; i++) issue(0, 3, 9, 0, 0, 32'(i + 1), 5'(11 + i));
    chk("t3_full", 32'(bus.full), 1);
    issue(0, 3, 0, 1, 0, 2, 20);
    chk("t3_full_hold", 32'(bus.full), 1);
    cdb(9, 77);
    chk("t3_wake_no_bypass", 32'(bus.ex_valid), 0);
    chk("t3_full_wake", 32'(bus.full), 1);
    tick();
    chk("t3_first_target", 32'(bus.ex_target), 11);
    chk("t3_first_a", bus.ex_a, 77);
    chk("t3_first_b", bus.ex_b, 1);
    chk("t3_not_full", 32'(bus.full), 0);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("t3_order", 32'(bus.ex_target), 32'(11 + i));
    end
    tick();
    chk("t3_fifth_ignored", 32'(bus.ex_valid), 0);
    // 4: back-pressure holds outputs
    bus.ex_ready = 0;
    issue(0, 1, 0, 100, 0, 200, 5);
    tick();
    chk("t4_valid", 32'(bus.ex_valid), 1);
    issue(0, 6, 0, 300, 0, 400, 6);
    issue(0, 7, 3, 0, 0, 500, 7);
    cdb(3, 600);
    tick();
    tick();
    chk("t4_hold_op", 32'(bus.ex_op), 1);
    chk("t4_hold_a", bus.ex_a, 100);
    chk("t4_hold_b", bus.ex_b, 200);
    chk("t4_hold_target", 32'(bus.ex_target), 5);
    chk("t4_hold_valid", 32'(bus.ex_valid), 1);
    bus.ex_ready = 1;
    tick();
    chk("t4_next_target", 32'(bus.ex_target), 6);
    tick();
    chk("t4_last_target", 32'(bus.ex_target), 7);
    chk("t4_last_a", bus.ex_a, 600);
    tick();
    chk("t4_drain", 32'(bus.ex_valid), 0);
    // 5: other unit ignored; one broadcast wakes both operands
    issue(1, 4, 0, 1, 0, 2, 9);
    chk("t5_full", 32'(bus.full), 0);
    tick();
    chk("t5_unit_ignored", 32'(bus.ex_valid), 0);
    issue(0, 4, 6, 0, 6, 0, 10);
    cdb(6, 33);
    tick();
    chk("t5_valid", 32'(bus.ex_valid), 1);
    chk("t5_a", bus.ex_a, 33);
    chk("t5_b", bus.ex_b, 33);
    chk("t5_target", 32'(bus.ex_target), 10);
    tick();
    chk("t5_drain", 32'(bus.ex_valid), 0);
    // 6: flush beats issue/dispatch, then async reset
    bus.ex_ready = 0;
    issue(0, 2, 0, 1, 0, 1, 1);
    tick();
    chk("t6_valid", 32'(bus.ex_valid), 1);
    for (int i = 0; i < 3; i++) issue(0, 2, 13, 0, 0, 0, 5'(2 + i));
    flush = 1;
    bus.ex_ready = 1;
    issue(0, 2, 0, 1, 0, 1, 21);
    flush = 0;
    chk("t6_flush_valid", 32'(bus.ex_valid), 0);
    chk("t6_flush_full", 32'(bus.full), 0);
    cdb(13, 5);
    tick();
    chk("t6_flush_empty", 32'(bus.ex_valid), 0);
    issue(0, 9, 0, 42, 0, 43, 17);
    tick();
    chk("t6_pre_rst", 32'(bus.ex_valid), 1);
    #2 rst = 1;
    #1;
    chk("t6_rst_valid", 32'(bus.ex_valid), 0);
    chk("t6_rst_a", bus.ex_a, 0);
    chk("t6_rst_target", 32'(bus.ex_target), 0);
    rst = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
